// File: rtl/pipe_pkg.sv
// Shared pipeline helpers: pointer arithmetic for non-power-of-two circular
// buffers and payload structs that stages pack into a stage buffer's WIDTH.
package pipe_pkg;

    localparam int unsigned PTR_W_MIN = 1;

    // Pointer width for a buffer of the given depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? PTR_W_MIN : $clog2(depth);
    endfunction

    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
    endfunction

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fd_payload_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [7:0]  alu_op;
    } de_payload_t;

endpackage

// File: rtl/pipe_stage_mem.sv
// DEPTH x WIDTH register array, one write port, asynchronous read, zero on reset.
module pipe_stage_mem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Address decode by comparison so DEPTH need not be a power of two.
    always_comb begin
        mem_d = mem_q;
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (we && (waddr == PTR_W'(i))) begin
                mem_d[i] = wdata;
            end
            if (raddr == PTR_W'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: up to DEPTH in-flight beats with payload,
// stage-local ready_go stall and synchronous flush.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_allow_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_allow_in,
    input  logic             ready_go,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = int'(ptr_width(DEPTH));
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Handshake: a beat moves on a side only in a cycle where both its valid
    // and its allow_in are 1 (push upstream, pop downstream). allow_in never
    // looks at the same side's valid, so no combinational loop can form; a
    // full buffer admits a beat only when its head leaves in the same cycle.
    always_comb begin
        in_allow_in = !flush && ((count_q < DEPTH_C) || (ready_go && out_allow_in));
        out_valid   = (count_q != '0) && ready_go && !flush;
        push        = in_valid && in_allow_in;
        pop         = out_valid && out_allow_in;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = PTR_W'(ptr_next(32'(wr_ptr_q), DEPTH));
            end
            if (pop) begin
                rd_ptr_d = PTR_W'(ptr_next(32'(rd_ptr_q), DEPTH));
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

    // When full, wr_ptr == rd_ptr: the head is read from the old contents
    // this cycle and the slot is overwritten at the edge.
    pipe_stage_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: four instances with DEPTH 1..4, directed scenarios
// and randomized traffic checked against a queue model of the stage.
module tb_pipe_stage_buf;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid     [N];
    logic [W-1:0] in_data      [N];
    logic         in_allow_in  [N];
    logic         out_valid    [N];
    logic [W-1:0] out_data     [N];
    logic         out_allow_in [N];
    logic         ready_go     [N];
    logic         flush        [N];
    logic [2:0]   cnt          [N];

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int CW = $clog2(g + 2);
        logic [CW-1:0] count_w;

        pipe_stage_buf #(
            .WIDTH (W),
            .DEPTH (g + 1)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid[g]),
            .in_data      (in_data[g]),
            .in_allow_in  (in_allow_in[g]),
            .out_valid    (out_valid[g]),
            .out_data     (out_data[g]),
            .out_allow_in (out_allow_in[g]),
            .ready_go     (ready_go[g]),
            .flush        (flush[g]),
            .count        (count_w)
        );

        assign cnt[g] = 3'(count_w);
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [W-1:0] d,
                         input logic oai, input logic rg, input logic fl);
        in_valid[i]     = v;
        in_data[i]      = d;
        out_allow_in[i] = oai;
        ready_go[i]     = rg;
        flush[i]        = fl;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drive(i, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- reference model ----------------
    // The stage is a FIFO of at most DEPTH beats; outputs follow from its size.
    task automatic model_eval(input int i, output logic ea, output logic ev,
                              output logic [W-1:0] ed);
        int depth;
        depth = i + 1;
        ea = !flush[i] && ((exp_q.size() < depth) || (ready_go[i] && out_allow_in[i]));
        ev = (exp_q.size() != 0) && ready_go[i] && !flush[i];
        ed = (exp_q.size() != 0) ? exp_q[0] : '0;
    endtask

    task automatic model_commit(input int i);
        logic ea, ev;
        logic [W-1:0] ed;
        model_eval(i, ea, ev, ed);
        if (flush[i]) begin
            exp_q.delete();
        end else begin
            if (ev && out_allow_in[i]) void'(exp_q.pop_front());
            if (in_valid[i] && ea) exp_q.push_back(in_data[i]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) begin
                drive(i, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (cnt[i] !== 3'd0) begin
                    n_err++; $display("FAIL reset_count[%0d]: got %0d expected 0", i, cnt[i]);
                end
                n_cmp++;
                if (out_valid[i] !== 1'b0) begin
                    n_err++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, out_valid[i]);
                end
                n_cmp++;
                if (out_data[i] !== '0) begin
                    n_err++; $display("FAIL reset_out_data[%0d]: got %0h expected 0", i, out_data[i]);
                end
                n_cmp++;
                if (in_allow_in[i] !== !flush[i]) begin
                    n_err++; $display("FAIL reset_allow[%0d]: got %b expected %b", i, in_allow_in[i], !flush[i]);
                end
            end
        end
        tick();
        idle_all();
        rst = 1'b1;
        tick();
        drive(0, 1'b1, 16'h00A5, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (in_allow_in[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_err++; $display("FAIL a5_push: allow=%b valid=%b expected allow=1 valid=0", in_allow_in[0], out_valid[0]);
        end
        tick();
        drive(0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 16'h00A5) begin
            n_err++; $display("FAIL a5_out: valid=%b data=%0h expected valid=1 data=a5", out_valid[0], out_data[0]);
        end
        tick();
        drive(0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (cnt[0] !== 3'd0) begin
            n_err++; $display("FAIL a5_drain_count: got %0d expected 0", cnt[0]);
        end
        tick();
    endtask

    task automatic test_stream();
        for (int k = 0; k <= 100; k++) begin
            drive(0, k < 100, W'(k), 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (in_allow_in[0] !== 1'b1) begin
                n_err++; $display("FAIL stream_allow k=%0d: got %b expected 1", k, in_allow_in[0]);
            end
            n_cmp++;
            if (out_valid[0] !== (k >= 1)) begin
                n_err++; $display("FAIL stream_valid k=%0d: got %b expected %b", k, out_valid[0], k >= 1);
            end
            if (k >= 1) begin
                n_cmp++;
                if (out_data[0] !== W'(k - 1)) begin
                    n_err++; $display("FAIL stream_data k=%0d: got %0d expected %0d", k, out_data[0], k - 1);
                end
            end
            tick();
        end
        drive(0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (out_valid[0] !== 1'b0 || cnt[0] !== 3'd0) begin
            n_err++; $display("FAIL stream_end: valid=%b count=%0d expected 0/0", out_valid[0], cnt[0]);
        end
        tick();
    endtask

    task automatic test_fill_wrap();
        for (int k = 0; k < 3; k++) begin
            drive(2, 1'b1, W'(10 + k), 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(2, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (cnt[2] !== 3'd3 || in_allow_in[2] !== 1'b0) begin
            n_err++; $display("FAIL fill_full: count=%0d allow=%b expected 3/0", cnt[2], in_allow_in[2]);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(2, 1'b1, W'(13 + k), 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (in_allow_in[2] !== 1'b1 || out_valid[2] !== 1'b1 || out_data[2] !== W'(10 + k)) begin
                n_err++; $display("FAIL wrap_pass k=%0d: allow=%b valid=%b data=%0d expected 1/1/%0d",
                                  k, in_allow_in[2], out_valid[2], out_data[2], 10 + k);
            end
            n_cmp++;
            if (cnt[2] !== 3'd3) begin
                n_err++; $display("FAIL wrap_count k=%0d: got %0d expected 3", k, cnt[2]);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(2, 1'b0, '0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (k < 3 && (out_valid[2] !== 1'b1 || out_data[2] !== W'(15 + k))) begin
                n_err++; $display("FAIL wrap_drain k=%0d: valid=%b data=%0d expected 1/%0d", k, out_valid[2], out_data[2], 15 + k);
            end else if (k == 3 && (out_valid[2] !== 1'b0 || cnt[2] !== 3'd0)) begin
                n_err++; $display("FAIL wrap_empty: valid=%b count=%0d expected 0/0", out_valid[2], cnt[2]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        drive(1, 1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 16'h0066, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (out_valid[1] !== 1'b0 || in_allow_in[1] !== 1'b1) begin
            n_err++; $display("FAIL stall_second: valid=%b allow=%b expected 0/1", out_valid[1], in_allow_in[1]);
        end
        tick();
        drive(1, 1'b1, 16'h0077, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (in_allow_in[1] !== 1'b0 || cnt[1] !== 3'd2) begin
            n_err++; $display("FAIL stall_refuse: allow=%b count=%0d expected 0/2", in_allow_in[1], cnt[1]);
        end
        tick();
        drive(1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 16'h0055) begin
            n_err++; $display("FAIL stall_head: valid=%b data=%0h expected 1/55", out_valid[1], out_data[1]);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 16'h0066) begin
            n_err++; $display("FAIL stall_second_out: valid=%b data=%0h expected 1/66", out_valid[1], out_data[1]);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (out_valid[1] !== 1'b0 || cnt[1] !== 3'd0) begin
            n_err++; $display("FAIL stall_refused_leak: valid=%b count=%0d expected 0/0", out_valid[1], cnt[1]);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(3, 1'b1, W'(16'h0030 + k), 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(3, 1'b1, 16'h00EE, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (in_allow_in[3] !== 1'b0 || out_valid[3] !== 1'b0) begin
            n_err++; $display("FAIL flush_comb: allow=%b valid=%b expected 0/0", in_allow_in[3], out_valid[3]);
        end
        tick();
        drive(3, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (cnt[3] !== 3'd0 || out_valid[3] !== 1'b0) begin
                n_err++; $display("FAIL flush_after k=%0d: count=%0d valid=%b expected 0/0", k, cnt[3], out_valid[3]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            drive(3, 1'b1, W'(16'h0040 + k), 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(3, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (cnt[3] !== 3'd2 || out_valid[3] !== 1'b1) begin
            n_err++; $display("FAIL arst_pre: count=%0d valid=%b expected 2/1", cnt[3], out_valid[3]);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (cnt[3] !== 3'd0 || out_valid[3] !== 1'b0 || out_data[3] !== '0) begin
            n_err++; $display("FAIL arst_now: count=%0d valid=%b data=%0h expected 0/0/0", cnt[3], out_valid[3], out_data[3]);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random(input int i, input int cycles);
        logic ea, ev;
        logic [W-1:0] ed;
        exp_q.delete();
        drive(i, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int c = 0; c < cycles; c++) begin
            drive(i, $urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 40) == 0);
            @(negedge clk);
            model_eval(i, ea, ev, ed);
            n_cmp++;
            if (in_allow_in[i] !== ea) begin
                n_err++; $display("FAIL rand_allow[%0d] c=%0d: got %b expected %b", i, c, in_allow_in[i], ea);
            end
            n_cmp++;
            if (out_valid[i] !== ev) begin
                n_err++; $display("FAIL rand_valid[%0d] c=%0d: got %b expected %b", i, c, out_valid[i], ev);
            end
            if (ev) begin
                n_cmp++;
                if (out_data[i] !== ed) begin
                    n_err++; $display("FAIL rand_data[%0d] c=%0d: got %0h expected %0h", i, c, out_data[i], ed);
                end
            end
            n_cmp++;
            if (cnt[i] !== 3'(exp_q.size())) begin
                n_err++; $display("FAIL rand_count[%0d] c=%0d: got %0d expected %0d", i, c, cnt[i], exp_q.size());
            end
            model_commit(i);
            tick();
        end
        drive(i, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        idle_all();
        rst = 1'b0;
        test_reset();
        test_stream();
        test_fill_wrap();
        test_stall();
        test_flush();
        test_async_reset();
        for (int i = 0; i < N; i++) test_random(i, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
